// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequencer that loads, kicks and drains one conv core job.
// Optional: define CONV_SEQ_PERF_EN to add the perf_cycles_o job-length counter.
module conv_seq_ctrl #(
   parameter int DATA_W   = 8,
   parameter int IFMAP_N  = 16,
   parameter int FILTER_N = 9,
   parameter int OUT_N    = 4,
   parameter int CORE_LAT = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   input  logic              ifmap_valid_i,
   input  logic [DATA_W-1:0] ifmap_data_i,
   output logic              ifmap_ready_o,
   input  logic              filter_valid_i,
   input  logic [DATA_W-1:0] filter_data_i,
   output logic              filter_ready_o,
   output logic              core_en_o,
   output logic              core_rst_o,
   output logic              core_done_serial1_o,
   output logic              core_done_serial2_o,
   output logic              core_done_para_o,
   output logic [DATA_W-1:0] core_in_ifmap_o,
   output logic [DATA_W-1:0] core_in_filter_o,
   input  logic [DATA_W-1:0] core_out_i,
   output logic              res_valid_o,
   output logic [DATA_W-1:0] res_data_o
`ifdef CONV_SEQ_PERF_EN
   ,
   output logic [15:0]       perf_cycles_o
`endif
);

   localparam int PARA_N = CORE_LAT + OUT_N;
   localparam int MAX_IF = (IFMAP_N > FILTER_N) ? IFMAP_N : FILTER_N;
   localparam int MAXN   = (MAX_IF > PARA_N) ? MAX_IF : PARA_N;
   localparam int CNT_W  = $clog2(MAXN + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_KICK,
      S_COMP,
      S_FIN
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  ifm_cnt_q;
   logic [CNT_W-1:0]  flt_cnt_q;
   logic [CNT_W-1:0]  ph_cnt_q;
   logic [CNT_W-1:0]  ifm_cnt_d;
   logic [CNT_W-1:0]  flt_cnt_d;
   logic              busy_q;
   logic              done_q;
   logic              en_q;
   logic              crst_q;
   logic              para_q;
   logic              s1_q;
   logic              s2_q;
   logic [DATA_W-1:0] in_ifm_q;
   logic [DATA_W-1:0] in_flt_q;
   logic              res_valid_q;
   logic [DATA_W-1:0] res_data_q;
   logic              ifm_rdy;
   logic              flt_rdy;
   logic              hs_i;
   logic              hs_f;
   logic              load_full_d;

   assign ifm_rdy = (state_q == S_LOAD) &&
                    (ifm_cnt_q < CNT_W'(IFMAP_N));
   assign flt_rdy = (state_q == S_LOAD) &&
                    (flt_cnt_q < CNT_W'(FILTER_N));
   assign hs_i    = ifmap_valid_i & ifm_rdy;
   assign hs_f    = filter_valid_i & flt_rdy;

   // Counts after this cycle's handshakes; lets LOAD exit on the last word.
   always_comb begin
      ifm_cnt_d   = hs_i ? ifm_cnt_q + CNT_W'(1) : ifm_cnt_q;
      flt_cnt_d   = hs_f ? flt_cnt_q + CNT_W'(1) : flt_cnt_q;
      load_full_d = (ifm_cnt_d == CNT_W'(IFMAP_N)) &&
                    (flt_cnt_d == CNT_W'(FILTER_N));
   end

   // Job FSM with all core control lines and result stream registered.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         ifm_cnt_q   <= '0;
         flt_cnt_q   <= '0;
         ph_cnt_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         en_q        <= 1'b0;
         crst_q      <= 1'b1;
         para_q      <= 1'b0;
         s1_q        <= 1'b0;
         s2_q        <= 1'b0;
         in_ifm_q    <= '0;
         in_flt_q    <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else begin
         done_q      <= 1'b0;
         crst_q      <= 1'b0;
         res_valid_q <= 1'b0;
         s1_q        <= hs_i;
         s2_q        <= hs_f;
         if (hs_i) begin
            in_ifm_q <= ifmap_data_i;
         end
         if (hs_f) begin
            in_flt_q <= filter_data_i;
         end
         unique case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q <= S_LOAD;
                  busy_q  <= 1'b1;
                  en_q    <= 1'b1;
               end
            end
            S_LOAD: begin
               ifm_cnt_q <= ifm_cnt_d;
               flt_cnt_q <= flt_cnt_d;
               if (load_full_d) begin
                  state_q <= S_KICK;
                  crst_q  <= 1'b1;
                  para_q  <= 1'b1;
               end
            end
            S_KICK: begin
               state_q  <= S_COMP;
               ph_cnt_q <= '0;
            end
            S_COMP: begin
               ph_cnt_q <= ph_cnt_q + CNT_W'(1);
               if (ph_cnt_q >= CNT_W'(CORE_LAT)) begin
                  res_valid_q <= 1'b1;
                  res_data_q  <= core_out_i;
               end
               if (ph_cnt_q == CNT_W'(PARA_N - 1)) begin
                  state_q <= S_FIN;
                  para_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            S_FIN: begin
               state_q   <= S_IDLE;
               busy_q    <= 1'b0;
               en_q      <= 1'b0;
               ifm_cnt_q <= '0;
               flt_cnt_q <= '0;
               ph_cnt_q  <= '0;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

`ifdef CONV_SEQ_PERF_EN
   logic [15:0] perf_q;

   // Job length from start accept through done, saturating, held while idle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_q <= '0;
      end else if (state_q == S_IDLE && start_i) begin
         perf_q <= 16'd1;
      end else if (busy_q && perf_q != 16'hFFFF) begin
         perf_q <= perf_q + 16'd1;
      end
   end

   assign perf_cycles_o = perf_q;
`endif

   assign busy_o              = busy_q;
   assign done_o              = done_q;
   assign ifmap_ready_o       = ifm_rdy;
   assign filter_ready_o      = flt_rdy;
   assign core_en_o           = en_q;
   assign core_rst_o          = crst_q;
   assign core_done_serial1_o = s1_q;
   assign core_done_serial2_o = s2_q;
   assign core_done_para_o    = para_q;
   assign core_in_ifmap_o     = in_ifm_q;
   assign core_in_filter_o    = in_flt_q;
   assign res_valid_o         = res_valid_q;
   assign res_data_o          = res_data_q;

endmodule
